// File: rtl/minicpu_pkg.sv
// Shared minicpu types: datapath width and writeback destination encoding.
`ifndef DATA_WIDTH
`define DATA_WIDTH 4
`endif

package minicpu_pkg;

  localparam int DATA_WIDTH = `DATA_WIDTH;

  typedef enum logic [1:0] {
    WB_REG_A     = 2'b00,
    WB_REG_B     = 2'b01,
    WB_PORT      = 2'b10,
    WB_FLAG_ONLY = 2'b11
  } wb_dst_e;

endpackage

// File: rtl/alu_writeback_if.sv
// Writeback request bus from the sequencer/ALU plus the output-port valid/ready stream.
interface alu_writeback_if
  import minicpu_pkg::*;
#(
  parameter int DATA_WIDTH = minicpu_pkg::DATA_WIDTH
);
  logic                  wb_en;
  wb_dst_e               wb_dst;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_c;
  logic                  stall;
  logic [DATA_WIDTH-1:0] port_data;
  logic                  port_valid;
  logic                  port_ready;

  modport master (
    output wb_en, wb_dst, alu_out, alu_c, port_ready,
    input  stall, port_data, port_valid
  );

  modport slave (
    input  wb_en, wb_dst, alu_out, alu_c, port_ready,
    output stall, port_data, port_valid
  );
endinterface

// File: rtl/wb_port_fifo.sv
// Small circular FIFO feeding the output port; a push into a full FIFO succeeds only alongside a pop.
module wb_port_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic                  full
);
  localparam int PW = $clog2(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [OUT_DEPTH];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW:0]           count_r;
  logic                  pop_s;
  logic                  push_s;

  assign valid  = (count_r != (PW+1)'(0));
  assign full   = (count_r == (PW+1)'(OUT_DEPTH));
  assign head   = mem_r[rd_ptr_r];
  assign pop_s  = pop & valid;
  // When full, the slot being written is the one popped this same cycle.
  assign push_s = push & (~full | pop_s);

  // Storage, pointers and occupancy; reset clears everything so head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/alu_writeback.sv
// ALU result sink: writes reg A/B, latches carry, and queues port writes behind a valid/ready FIFO.
module alu_writeback
  import minicpu_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_writeback_if.slave        wb,
  output logic [DATA_WIDTH-1:0] reg_a,
  output logic [DATA_WIDTH-1:0] reg_b,
  output logic                  carry
);
  logic [DATA_WIDTH-1:0] reg_a_r;
  logic [DATA_WIDTH-1:0] reg_b_r;
  logic                  carry_r;
  logic                  fifo_full_s;
  logic                  port_sel_s;
  logic                  stall_s;
  logic                  acc_s;
  logic                  push_s;
  logic                  pop_s;

  assign port_sel_s = (wb.wb_dst == WB_PORT);
  // A full FIFO still takes the write when the consumer drains the head this cycle.
  assign stall_s    = wb.wb_en & port_sel_s & fifo_full_s & ~wb.port_ready;
  assign acc_s      = wb.wb_en & ~stall_s;
  assign push_s     = acc_s & port_sel_s;
  assign pop_s      = wb.port_valid & wb.port_ready;

  assign wb.stall = stall_s;
  assign reg_a    = reg_a_r;
  assign reg_b    = reg_b_r;
  assign carry    = carry_r;

  // Register file and carry flag update on every accepted writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_r <= '0;
      reg_b_r <= '0;
      carry_r <= 1'b0;
    end else if (acc_s) begin
      carry_r <= wb.alu_c;
      case (wb.wb_dst)
        WB_REG_A: reg_a_r <= wb.alu_out;
        WB_REG_B: reg_b_r <= wb.alu_out;
        default: begin
          reg_a_r <= reg_a_r;
          reg_b_r <= reg_b_r;
        end
      endcase
    end
  end

  wb_port_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_DEPTH  (OUT_DEPTH)
  ) u_port_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (wb.alu_out),
    .pop       (pop_s),
    .head      (wb.port_data),
    .valid     (wb.port_valid),
    .full      (fifo_full_s)
  );
endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback: register writes, carry, port FIFO, stall and reset.
module tb_alu_writeback;
  import minicpu_pkg::*;

  logic clk;
  logic rst_n;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;
  int checks;
  int errors;

  alu_writeback_if #(.DATA_WIDTH(4)) bus ();

  alu_writeback #(.OUT_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus.slave),
    .reg_a (reg_a),
    .reg_b (reg_b),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_en      = 1'b0;
    bus.wb_dst     = WB_REG_A;
    bus.alu_out    = 4'h0;
    bus.alu_c      = 1'b0;
    bus.port_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got a=%h b=%h c=%b want a=0 b=0 c=0", reg_a, reg_b, carry);
    end
    checks++;
    if (bus.port_valid !== 1'b0 || bus.port_data !== 4'h0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_port: got v=%b d=%h s=%b want v=0 d=0 s=0",
               bus.port_valid, bus.port_data, bus.stall);
    end
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_reg_writes();
    bus.wb_en = 1'b1; bus.wb_dst = WB_REG_A; bus.alu_out = 4'b1111; bus.alu_c = 1'b1;
    step();
    checks++;
    if (reg_a !== 4'hF || carry !== 1'b1) begin
      errors++;
      $display("FAIL write_a: got a=%h c=%b want a=f c=1", reg_a, carry);
    end
    bus.wb_dst = WB_REG_B; bus.alu_out = 4'b0001; bus.alu_c = 1'b0;
    step();
    checks++;
    if (reg_b !== 4'h1 || carry !== 1'b0 || reg_a !== 4'hF) begin
      errors++;
      $display("FAIL write_b: got a=%h b=%h c=%b want a=f b=1 c=0", reg_a, reg_b, carry);
    end
    bus.wb_en = 1'b0; bus.alu_c = 1'b1; bus.wb_dst = WB_REG_A; bus.alu_out = 4'h6;
    step();
    checks++;
    if (reg_a !== 4'hF || carry !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got a=%h c=%b want a=f c=0", reg_a, carry);
    end
  endtask

  task automatic test_flag_only();
    bus.wb_en = 1'b1; bus.wb_dst = WB_FLAG_ONLY; bus.alu_out = 4'b1010; bus.alu_c = 1'b1;
    step();
    bus.wb_en = 1'b0;
    checks++;
    if (carry !== 1'b1 || reg_a !== 4'hF || reg_b !== 4'h1 || bus.port_valid !== 1'b0) begin
      errors++;
      $display("FAIL flag_only: got c=%b a=%h b=%h v=%b want c=1 a=f b=1 v=0",
               carry, reg_a, reg_b, bus.port_valid);
    end
  endtask

  task automatic test_port_stall();
    bus.port_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_dst = WB_PORT; bus.alu_c = 1'b0; bus.alu_out = 4'd3;
    step();
    checks++;
    if (bus.port_valid !== 1'b1 || bus.port_data !== 4'd3) begin
      errors++;
      $display("FAIL push_first: got v=%b d=%h want v=1 d=3", bus.port_valid, bus.port_data);
    end
    bus.alu_out = 4'd5;
    step();
    bus.alu_out = 4'd7; bus.alu_c = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_full: got stall=%b want 1", bus.stall);
    end
    // Head must hold steady while the consumer withholds ready.
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.port_data !== 4'd3 || bus.port_valid !== 1'b1 || bus.stall !== 1'b1 || carry !== 1'b0) begin
        errors++;
        $display("FAIL hold_head[%0d]: got d=%h v=%b s=%b c=%b want d=3 v=1 s=1 c=0",
                 i, bus.port_data, bus.port_valid, bus.stall, carry);
      end
    end
    bus.port_ready = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got stall=%b want 0", bus.stall);
    end
    step();
    bus.wb_en = 1'b0;
    checks++;
    if (bus.port_data !== 4'd5 || bus.port_valid !== 1'b1 || carry !== 1'b1) begin
      errors++;
      $display("FAIL drain_5: got d=%h v=%b c=%b want d=5 v=1 c=1", bus.port_data, bus.port_valid, carry);
    end
    step();
    checks++;
    if (bus.port_data !== 4'd7 || bus.port_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_7: got d=%h v=%b want d=7 v=1", bus.port_data, bus.port_valid);
    end
    step();
    checks++;
    if (bus.port_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: got v=%b want 0", bus.port_valid);
    end
    bus.port_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int pushed;
    int got[$];
    int cyc;
    pushed = 0;
    cyc    = 0;
    got.delete();
    bus.wb_dst = WB_PORT;
    while ((pushed < 10 || got.size() < 10) && cyc < 100) begin
      bus.port_ready = (cyc % 2 == 0);
      bus.wb_en      = (pushed < 10);
      bus.alu_out    = 4'(pushed);
      #3;
      if (bus.port_valid && bus.port_ready) got.push_back(int'(bus.port_data));
      if (bus.wb_en && !bus.stall) pushed++;
      cyc++;
      step();
    end
    bus.wb_en = 1'b0;
    bus.port_ready = 1'b0;
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL wrap_count: got %0d words want 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      checks++;
      if (got[i] != i) begin
        errors++;
        $display("FAIL wrap_order[%0d]: got %0d want %0d", i, got[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.port_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_dst = WB_REG_A; bus.alu_out = 4'h9; bus.alu_c = 1'b1;
    step();
    bus.wb_dst = WB_PORT; bus.alu_out = 4'h1;
    step();
    bus.alu_out = 4'h2;
    step();
    bus.wb_en = 1'b0;
    checks++;
    if (bus.port_valid !== 1'b1 || reg_a !== 4'h9 || carry !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got v=%b a=%h c=%b want v=1 a=9 c=1", bus.port_valid, reg_a, carry);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0 || bus.port_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got a=%h b=%h c=%b v=%b want all 0",
               reg_a, reg_b, carry, bus.port_valid);
    end
    #10 rst_n = 1'b1;
    step();
    checks++;
    if (bus.port_valid !== 1'b0 || bus.port_data !== 4'h0) begin
      errors++;
      $display("FAIL post_reset: got v=%b d=%h want v=0 d=0", bus.port_valid, bus.port_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reg_writes();
    test_flag_only();
    test_port_stall();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
